// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// One shared hex decoder; new contents are committed only at frame boundaries.

// Hex nibble to active-low segment pattern, a_to_g = {a,b,c,d,e,f,g}.
module hex7seg (
  input  logic [3:0] x,
  output logic [6:0] a_to_g
);

  // Glyph table for 0-9, A, b, C, d, E, F
  always_comb begin
    a_to_g = 7'b1111111;
    case (x)
      4'h0: a_to_g = 7'b0000001;
      4'h1: a_to_g = 7'b1001111;
      4'h2: a_to_g = 7'b0010010;
      4'h3: a_to_g = 7'b0000110;
      4'h4: a_to_g = 7'b1001100;
      4'h5: a_to_g = 7'b0100100;
      4'h6: a_to_g = 7'b0100000;
      4'h7: a_to_g = 7'b0001111;
      4'h8: a_to_g = 7'b0000000;
      4'h9: a_to_g = 7'b0000100;
      4'hA: a_to_g = 7'b0001000;
      4'hB: a_to_g = 7'b1100000;
      4'hC: a_to_g = 7'b0110001;
      4'hD: a_to_g = 7'b1000010;
      4'hE: a_to_g = 7'b0110000;
      default: a_to_g = 7'b0111000;
    endcase
  end

endmodule

module seg7_scan_ctrl #(
  parameter int unsigned NDIG     = 8,
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                load,
  input  logic [4*NDIG-1:0]   data,
  input  logic [NDIG-1:0]     dp_in,
  input  logic                blank_lz,
  output logic [NDIG-1:0]     an,
  output logic [6:0]          a_to_g,
  output logic                dp,
  output logic                pending,
  output logic                frame_done
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = $clog2(NDIG);
  localparam int unsigned DW    = 4 * NDIG;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DW-1:0]    sh_data_q, sh_data_d;
  logic [NDIG-1:0]  sh_dp_q, sh_dp_d;
  logic [DW-1:0]    buf_data_q, buf_data_d;
  logic [NDIG-1:0]  buf_dp_q, buf_dp_d;
  logic             pending_q, pending_d;
  logic             frame_done_q, frame_done_d;
  logic [NDIG-1:0]  an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic             tick_c;
  logic             frame_end_c;
  logic             commit_c;
  logic [3:0]       nib_c;
  logic             dp_sel_c;
  logic             blank_c;
  logic             upper_zero_c;
  logic [6:0]       dec_seg_c;

  // Prescaler and digit index; both parked at zero while disabled
  always_comb begin
    tick_c      = en && (cnt_q == CNT_W'(SCAN_DIV - 1));
    frame_end_c = tick_c && (idx_q == IDX_W'(NDIG - 1));
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    if (!en) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (tick_c) begin
      cnt_d = '0;
      idx_d = frame_end_c ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    frame_done_d = frame_end_c;
  end

  // Load buffering; a disabled display has no frame to tear, so it commits at once
  always_comb begin
    commit_c   = frame_end_c || !en;
    sh_data_d  = sh_data_q;
    sh_dp_d    = sh_dp_q;
    buf_data_d = buf_data_q;
    buf_dp_d   = buf_dp_q;
    pending_d  = pending_q;
    if (commit_c && load) begin
      sh_data_d = data;
      sh_dp_d   = dp_in;
      pending_d = 1'b0;
    end else if (commit_c && pending_q) begin
      sh_data_d = buf_data_q;
      sh_dp_d   = buf_dp_q;
      pending_d = 1'b0;
    end else if (load) begin
      buf_data_d = data;
      buf_dp_d   = dp_in;
      pending_d  = 1'b1;
    end
  end

  // Select the active nibble/dp and decide leading-zero blanking top-down
  always_comb begin
    nib_c        = 4'h0;
    dp_sel_c     = 1'b0;
    blank_c      = 1'b0;
    upper_zero_c = 1'b1;
    for (int i = int'(NDIG) - 1; i >= 0; i--) begin
      upper_zero_c = upper_zero_c & (sh_data_q[4*i +: 4] == 4'h0);
      if (IDX_W'(i) == idx_q) begin
        nib_c    = sh_data_q[4*i +: 4];
        dp_sel_c = sh_dp_q[i];
        blank_c  = blank_lz & upper_zero_c & (i != 0);
      end
    end
  end

  hex7seg u_hex7seg (
    .x      (nib_c),
    .a_to_g (dec_seg_c)
  );

  // Next display pin values for the current digit
  always_comb begin
    an_d  = en ? ~(NDIG'(1) << idx_q) : '1;
    seg_d = (!en || blank_c) ? 7'b1111111 : dec_seg_c;
    dp_d  = ~(dp_sel_c & en);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      sh_data_q    <= '0;
      sh_dp_q      <= '0;
      buf_data_q   <= '0;
      buf_dp_q     <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      sh_data_q    <= sh_data_d;
      sh_dp_q      <= sh_dp_d;
      buf_data_q   <= buf_data_d;
      buf_dp_q     <= buf_dp_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an         = an_q;
  assign a_to_g     = seg_q;
  assign dp         = dp_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl against a frame-position reference model.
module tb_seg7_scan_ctrl;

  localparam int unsigned NDIG     = 4;
  localparam int unsigned SCAN_DIV = 4;
  localparam int          FRAME    = NDIG * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;

  wire [3:0]   an;
  wire [6:0]   a_to_g;
  wire         dp;
  wire         pending;
  wire         frame_done;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NDIG(NDIG), .SCAN_DIV(SCAN_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .data       (data),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .an         (an),
    .a_to_g     (a_to_g),
    .dp         (dp),
    .pending    (pending),
    .frame_done (frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: m_t = enabled cycles since the scan (re)started
  logic [15:0] m_sh = '0, m_buf = '0;
  logic [3:0]  m_shdp = '0, m_bufdp = '0;
  bit          m_pend = 1'b0;
  int          m_t = 0;
  logic [13:0] expv = '0;  // {an, a_to_g, dp, pending, frame_done}
  wire  [13:0] obs = {an, a_to_g, dp, pending, frame_done};

  // Active-low glyph from the positive-logic set of lit segments {a..g}
  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] lit;
    case (v)
      4'h0: lit = 7'b1111110;
      4'h1: lit = 7'b0110000;
      4'h2: lit = 7'b1101101;
      4'h3: lit = 7'b1111001;
      4'h4: lit = 7'b0110011;
      4'h5: lit = 7'b1011011;
      4'h6: lit = 7'b1011111;
      4'h7: lit = 7'b1110000;
      4'h8: lit = 7'b1111111;
      4'h9: lit = 7'b1111011;
      4'hA: lit = 7'b1110111;
      4'hB: lit = 7'b0011111;
      4'hC: lit = 7'b1001110;
      4'hD: lit = 7'b0111101;
      4'hE: lit = 7'b1001111;
      default: lit = 7'b1000111;
    endcase
    return ~lit;
  endfunction

  // Digit d is blanked when it and everything to its left is zero
  function automatic bit is_blank(input logic [15:0] sh, input int d, input bit blz);
    return blz && (d > 0) && ((sh >> (4 * d)) == 16'h0);
  endfunction

  // Reference model: predicts the registered outputs after every clock edge
  always @(posedge clk) begin : model
    int d;
    bit fe;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    if (rst) begin
      m_sh = '0; m_buf = '0; m_shdp = '0; m_bufdp = '0; m_pend = 1'b0; m_t = 0;
      expv = {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0};
    end else begin
      d     = en ? (m_t / SCAN_DIV) % NDIG : 0;
      e_an  = en ? ~(4'(1) << d) : 4'hF;
      e_seg = (!en || is_blank(m_sh, d, blank_lz)) ? 7'h7F : seg_of(4'(m_sh >> (4 * d)));
      fe    = en && ((m_t % FRAME) == FRAME - 1);
      expv[13:2] = {e_an, e_seg, ~(m_shdp[d] & en)};
      if ((fe || !en) && load) begin
        m_sh = data; m_shdp = dp_in; m_pend = 1'b0;
      end else if ((fe || !en) && m_pend) begin
        m_sh = m_buf; m_shdp = m_bufdp; m_pend = 1'b0;
      end else if (load) begin
        m_buf = data; m_bufdp = dp_in; m_pend = 1'b1;
      end
      expv[1:0] = {m_pend, fe};
      m_t = en ? m_t + 1 : 0;
    end
  end

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (an !== 4'hF || a_to_g !== 7'h7F || dp !== 1'b1 || pending !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got an=%b seg=%b dp=%b pend=%b fd=%b want 1111 1111111 1 0 0", an, a_to_g, dp, pending, frame_done);
    end
    n_checks++;
    if (obs !== expv) begin n_fail++; $display("FAIL reset_model: got %b want %b", obs, expv); end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    logic [3:0] want_an;
    en = 1'b1;
    for (int k = 0; k < 5 * SCAN_DIV + 4; k++) begin
      @(negedge clk);
      want_an = ~(4'(1) << ((k / SCAN_DIV) % NDIG));
      n_checks++;
      if (an !== want_an) begin n_fail++; $display("FAIL scan_an k=%0d: got %b want %b", k, an, want_an); end
      n_checks++;
      if (obs !== expv) begin n_fail++; $display("FAIL scan_model k=%0d: got %b want %b", k, obs, expv); end
    end
  endtask

  task automatic test_load_commit();
    bit seen;
    logic [6:0] want_seg;
    repeat ($urandom_range(1, 5)) @(negedge clk);
    if ((m_t % FRAME) == FRAME - 1) @(negedge clk);
    load = 1'b1; data = 16'h12AF; dp_in = 4'b0100;
    @(negedge clk);
    load = 1'b0;
    n_checks++;
    if (pending !== 1'b1) begin n_fail++; $display("FAIL load_pending: got %b want 1", pending); end
    seen = 1'b0;
    for (int k = 0; k < 2 * FRAME && !seen; k++) begin
      if (frame_done === 1'b1) seen = 1'b1;
      else begin
        n_checks++;
        if (obs !== expv) begin n_fail++; $display("FAIL load_wait_model: got %b want %b", obs, expv); end
        @(negedge clk);
      end
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL load_frame_done: got no pulse want pulse within %0d cycles", 2 * FRAME); end
    n_checks++;
    if (pending !== 1'b0) begin n_fail++; $display("FAIL load_commit_pending: got %b want 0", pending); end
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      case (an)
        4'b1110: want_seg = seg_of(4'hF);
        4'b1101: want_seg = seg_of(4'hA);
        4'b1011: want_seg = seg_of(4'h2);
        default: want_seg = seg_of(4'h1);
      endcase
      n_checks++;
      if (a_to_g !== want_seg || dp !== (an != 4'b1011) || frame_done !== (k == FRAME - 1)) begin
        n_fail++;
        $display("FAIL load_digits k=%0d: got an=%b seg=%b dp=%b fd=%b want seg=%b dp=%b", k, an, a_to_g, dp, frame_done, want_seg, an != 4'b1011);
      end
    end
  endtask

  task automatic test_blank();
    logic [15:0] vals [2];
    logic [6:0] want_seg;
    bit seen;
    vals[0] = 16'h0030; vals[1] = 16'h0000;
    blank_lz = 1'b1; dp_in = 4'b0000;
    for (int v = 0; v < 2; v++) begin
      load = 1'b1; data = vals[v];
      @(negedge clk);
      load = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 2 * FRAME && !seen; k++) begin
        if (frame_done === 1'b1) seen = 1'b1;
        else begin
          n_checks++;
          if (obs !== expv) begin n_fail++; $display("FAIL blank_wait_model v=%0d: got %b want %b", v, obs, expv); end
          @(negedge clk);
        end
      end
      n_checks++;
      if (!seen) begin n_fail++; $display("FAIL blank_frame_done v=%0d: got no pulse want pulse", v); end
      for (int k = 0; k < FRAME; k++) begin
        @(negedge clk);
        if (an == 4'b1110) want_seg = seg_of(4'h0);
        else if (an == 4'b1101 && v == 0) want_seg = seg_of(4'h3);
        else want_seg = 7'h7F;
        n_checks++;
        if (a_to_g !== want_seg) begin n_fail++; $display("FAIL blank_digit v=%0d an=%b: got %b want %b", v, an, a_to_g, want_seg); end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit seen;
    bit fe_next;
    logic [6:0] want_seg;
    seen = 1'b0;
    for (int k = 0; k < 2 * FRAME && !seen; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    load = 1'b1; data = 16'h1111; dp_in = 4'b0000;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    load = 1'b1; data = 16'h2222;
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      n_checks++;
      if (a_to_g === seg_of(4'h1)) begin n_fail++; $display("FAIL b2b_overwritten_shown k=%0d: got %b want anything but %b", k, a_to_g, seg_of(4'h1)); end
      n_checks++;
      if (obs !== expv) begin n_fail++; $display("FAIL b2b_model k=%0d: got %b want %b", k, obs, expv); end
      @(negedge clk);
    end
    n_checks++;
    if (a_to_g !== seg_of(4'h2)) begin n_fail++; $display("FAIL b2b_last_wins: got %b want %b", a_to_g, seg_of(4'h2)); end
    // Load exactly on the frame-end edge
    fe_next = 1'b0;
    for (int k = 0; k < 2 * FRAME && !fe_next; k++) begin
      if ((m_t % FRAME) == FRAME - 1) fe_next = 1'b1;
      else @(negedge clk);
    end
    load = 1'b1; data = 16'h3456;
    @(negedge clk);
    load = 1'b0;
    n_checks++;
    if (pending !== 1'b0 || frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_end_load: got pend=%b fd=%b want pend=0 fd=1", pending, frame_done);
    end
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      case (an)
        4'b1110: want_seg = seg_of(4'h6);
        4'b1101: want_seg = seg_of(4'h5);
        4'b1011: want_seg = seg_of(4'h4);
        default: want_seg = seg_of(4'h3);
      endcase
      n_checks++;
      if (pending !== 1'b0 || a_to_g !== want_seg) begin
        n_fail++;
        $display("FAIL frame_end_direct k=%0d: got pend=%b seg=%b want pend=0 seg=%b", k, pending, a_to_g, want_seg);
      end
    end
  endtask

  task automatic test_en_off();
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      load = (k == 4);
      data = 16'hBEEF; dp_in = 4'b1001;
      @(negedge clk);
      n_checks++;
      if (an !== 4'hF || dp !== 1'b1 || frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL en_off k=%0d: got an=%b dp=%b fd=%b want 1111 1 0", k, an, dp, frame_done);
      end
      n_checks++;
      if (obs !== expv) begin n_fail++; $display("FAIL en_off_model k=%0d: got %b want %b", k, obs, expv); end
    end
    load = 1'b0;
    en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (an !== 4'b1110 || a_to_g !== seg_of(4'hF) || dp !== 1'b0) begin
      n_fail++;
      $display("FAIL en_resume: got an=%b seg=%b dp=%b want 1110 %b 0", an, a_to_g, dp, seg_of(4'hF));
    end
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== expv) begin n_fail++; $display("FAIL en_resume_model k=%0d: got %b want %b", k, obs, expv); end
    end
  endtask

  task automatic test_reset_mid();
    bit at_slot;
    at_slot = 1'b0;
    for (int k = 0; k < 2 * FRAME && !at_slot; k++) begin
      if ((m_t % FRAME) == 2 * SCAN_DIV) at_slot = 1'b1;
      else @(negedge clk);
    end
    load = 1'b1; data = 16'h5555; dp_in = 4'b1111;
    @(negedge clk);
    load = 1'b0;
    n_checks++;
    if (pending !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pending: got %b want 1", pending); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (an !== 4'hF || a_to_g !== 7'h7F || dp !== 1'b1 || pending !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_values: got an=%b seg=%b dp=%b pend=%b fd=%b want 1111 1111111 1 0 0", an, a_to_g, dp, pending, frame_done);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (an !== 4'b1110) begin n_fail++; $display("FAIL rst_mid_restart: got an=%b want 1110", an); end
    for (int k = 0; k < 2 * FRAME; k++) begin
      n_checks++;
      if (a_to_g !== seg_of(4'h0) || dp !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_mid_cleared k=%0d: got seg=%b dp=%b want %b 1", k, a_to_g, dp, seg_of(4'h0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      rst      = ($urandom_range(0, 399) == 0);
      load     = ($urandom_range(0, 7) == 0);
      data     = 16'($urandom);
      if ($urandom_range(0, 3) == 0) data[15:8] = 8'h00;
      dp_in    = 4'($urandom);
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 59) == 0) blank_lz = ~blank_lz;
      @(negedge clk);
      n_checks++;
      if (obs !== expv) begin n_fail++; $display("FAIL random_model k=%0d: got %b want %b", k, obs, expv); end
    end
    rst = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load_commit();
    test_blank();
    test_back_to_back();
    test_en_off();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
